fg_pe_array: RTL
================

# fg_pe_array

Parametrised, pipelined array of LANES polar-decoder node processing elements. Each lane computes either the min-sum F function or the partial-sum-controlled G function on signed LLRs with symmetric saturation. A beat counter frames multi-beat nodes and generates `m_last`. The block sits between the LLR memory read port and the LLR write-back / hard-decision stage of the SC decoder datapath, with valid/ready handshakes on both sides.

## Interface
- `LANES`, 8: parallel PEs per beat.
- `LLR_W`, 6: two's-complement LLR width, inputs and outputs.
- `BEAT_W`, 5: width of the beats-per-node field.
- `SATCNT_W`, 16: width of the saturation event counter.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat accepted when `s_valid & s_ready`.
- `s_mode`  in  1  0 = F, 1 = G; sampled on the first beat of a node only.
- `s_beats_m1`  in  BEAT_W  node length in beats minus 1; sampled on the first beat only.
- `s_llr_a`  in  LANES*LLR_W  operand a (lane i at bits [i*LLR_W +: LLR_W]).
- `s_llr_b`  in  LANES*LLR_W  operand b.
- `s_ps`  in  LANES  per-lane partial sum u, used in G mode only.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_llr`  out  LANES*LLR_W  results.
- `m_last`  out  1  final beat of the node.
- `m_sat`  out  LANES  per-lane saturation occurred on this beat.
- `sat_cnt`  out  SATCNT_W  total saturated lane-results since reset; sticks at all-ones.

## Operation
- Legal range is symmetric: MAX = 2^(LLR_W-1)-1, MIN = -MAX. An input of -2^(LLR_W-1) is clamped to MIN on entry. This clamp does not set `m_sat`.
- F: `sign(a) XOR sign(b)` applied to `min(|a|,|b|)`. The result is always in range and `m_sat` = 0.
- G: `(ps ? -a : a) + b`, computed at LLR_W+1 bits.
  - If the result > MAX, output MAX and set `m_sat`.
  - If the result < MIN, output MIN and set `m_sat`.
- Beat counter `cnt`:
  - On an accepted beat with `cnt == 0`, latch `s_mode` into `mode_q` and `s_beats_m1` into `len_q`. That beat uses `s_mode` directly.
  - Later beats of the node use `mode_q` and ignore `s_mode` and `s_beats_m1`.
  - The beat is last when `cnt == len_q` (or when `s_beats_m1 == 0` on the first beat). `cnt` then wraps to 0; otherwise it increments.
  - `m_last` is computed at the input and travels with the beat.
- `sat_cnt` adds popcount(`m_sat`) on each output handshake and saturates at 2^SATCNT_W-1.

## Timing
- Two-stage pipeline.
  - S1 registers the clamped operands, the negation/abs results, the effective mode, ps and last.
  - S2 registers the result, `m_sat` and `m_last`.
- Latency is 2 cycles from input handshake to `m_valid` when unstalled. Throughput is 1 beat/cycle.
- Flow control:
  - S2 loads when `!v2 | m_ready`. S1 loads when `!v1 | (S2 loads)`.
  - `s_ready = !v1 | !v2 | m_ready`. Bubbles collapse.
  - No combinational path from `s_valid` to `s_ready`.
- While `m_valid & !m_ready`, `m_llr`, `m_last` and `m_sat` hold stable.
- Reset values: v1 = v2 = 0, `m_valid` = 0, `m_llr` = 0, `m_last` = 0, `m_sat` = 0, `sat_cnt` = 0, `cnt` = 0, `mode_q` = 0, `len_q` = 0.
- Reset mid-node flushes both stages and `cnt`. The next accepted beat starts a new node.
- A simultaneous `sat_cnt` increment and saturation clamps to all-ones; no wrap.

## Structure
- Package `pe_pkg`:
  - `MODE_F` / `MODE_G` constants.
  - `llr_max(W)` / `llr_min(W)` functions.
  - `sat_clamp` function, (W+1)-bit to W-bit plus a flag.
- Sub-module `fg_pe_lane`:
  - One lane of combinational F/G plus saturation, parametrised by LLR_W.
  - Instantiated LANES times by generate, with the S1 split inside it.
- Top level owns the handshake, pipeline valids, beat counter and `sat_cnt`.

## Test plan
- G, LLR_W=6, a=20, b=15, ps=0 -> 31, `m_sat`=1. Same with ps=1 -> -5, `m_sat`=0. a=-32 (clamped to -31), b=-10, ps=0 -> -31, `m_sat`=1.
- F, a=-7, b=12 -> -7. a=-31, b=-31 -> 31. a=0, b=-5 -> 0. `m_sat`=0 in all cases.
- Node of 4 beats (`s_beats_m1`=3, mode G), `s_mode` toggled on beats 2–4 -> all beats computed as G, `m_last` only on beat 4. The next node starts with a fresh sample of `s_mode`.
- Continuous input with `m_ready` toggling 1,0,0,1 -> no beat lost or duplicated, outputs stable while stalled, `s_ready` low only when both stages are full and `m_ready`=0.
- `rst` asserted mid-node after 2 of 4 beats -> `m_valid`=0 the next cycle, `sat_cnt`=0. The next beat starts a new node and uses its own `s_beats_m1`.
- SATCNT_W=4, 2 beats with 8 saturating lanes each -> `sat_cnt` holds at 15.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and saturation helpers for the F/G node processing elements.
package pe_pkg;

  localparam logic MODE_F = 1'b0;
  localparam logic MODE_G = 1'b1;

  // Result of a symmetric saturation: clamped value plus an overflow flag.
  typedef struct packed {
    logic               sat;
    logic signed [31:0] val;
  } clamp_t;

  // Largest representable magnitude in a symmetric W-bit LLR.
  function automatic int llr_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative legal LLR; the two's-complement extreme is excluded.
  function automatic int llr_min(input int unsigned w);
    return -llr_max(w);
  endfunction

  // Clamp a (W+1)-bit sum, held in an int, to the symmetric W-bit range.
  function automatic clamp_t sat_clamp(input int x, input int unsigned w);
    clamp_t r;
    r.sat = 1'b0;
    r.val = x;
    if (x > llr_max(w)) begin
      r.val = llr_max(w);
      r.sat = 1'b1;
    end else if (x < llr_min(w)) begin
      r.val = llr_min(w);
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fg_pe_lane.sv
// One polar-decoder PE lane: entry clamp + abs/negate (S1), F/G + saturation (S2).
module fg_pe_lane
  import pe_pkg::*;
#(
  parameter int unsigned LLR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic             mode1,
  input  logic [LLR_W-1:0] a,
  input  logic [LLR_W-1:0] b,
  input  logic             ps,
  output logic [LLR_W-1:0] res,
  output logic             sat
);

  localparam logic [LLR_W-1:0] NEG_FULL = {1'b1, {(LLR_W-1){1'b0}}};
  localparam logic [LLR_W-1:0] MIN_V    = NEG_FULL + LLR_W'(1);

  logic [LLR_W-1:0] a_cl, b_cl, a_neg, abs_a, abs_b;
  logic [LLR_W-1:0] a1, b1, a_neg1, abs_a1, abs_b1;
  logic             ps1;
  logic [LLR_W-1:0] mag, f_res, g_op, res_d;
  logic [LLR_W:0]   g_sum;
  logic             sat_d;
  clamp_t           g_cl;

  // Entry clamp of the asymmetric extreme, then negation and magnitudes.
  always_comb begin
    a_cl  = (a == NEG_FULL) ? MIN_V : a;
    b_cl  = (b == NEG_FULL) ? MIN_V : b;
    a_neg = -a_cl;
    abs_a = a_cl[LLR_W-1] ? a_neg : a_cl;
    abs_b = b_cl[LLR_W-1] ? -b_cl : b_cl;
  end

  // S1 operand register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a1     <= '0;
      b1     <= '0;
      a_neg1 <= '0;
      abs_a1 <= '0;
      abs_b1 <= '0;
      ps1    <= 1'b0;
    end else if (en1) begin
      a1     <= a_cl;
      b1     <= b_cl;
      a_neg1 <= a_neg;
      abs_a1 <= abs_a;
      abs_b1 <= abs_b;
      ps1    <= ps;
    end
  end

  // Min-sum F and partial-sum G with symmetric saturation on the G sum.
  always_comb begin
    mag   = (abs_a1 < abs_b1) ? abs_a1 : abs_b1;
    f_res = (a1[LLR_W-1] ^ b1[LLR_W-1]) ? -mag : mag;
    g_op  = ps1 ? a_neg1 : a1;
    g_sum = {g_op[LLR_W-1], g_op} + {b1[LLR_W-1], b1};
    g_cl  = sat_clamp(int'(signed'(g_sum)), LLR_W);
    if (mode1 == MODE_F) begin
      res_d = f_res;
      sat_d = 1'b0;
    end else begin
      res_d = LLR_W'(g_cl.val);
      sat_d = g_cl.sat;
    end
  end

  // S2 result register; holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      sat <= 1'b0;
    end else if (en2) begin
      res <= res_d;
      sat <= sat_d;
    end
  end

endmodule

// File: rtl/fg_pe_array.sv
// LANES-wide F/G PE array with valid/ready pipeline, node beat framing and saturation count.
module fg_pe_array
  import pe_pkg::*;
#(
  parameter int unsigned LANES    = 8,
  parameter int unsigned LLR_W    = 6,
  parameter int unsigned BEAT_W   = 5,
  parameter int unsigned SATCNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_mode,
  input  logic [BEAT_W-1:0]      s_beats_m1,
  input  logic [LANES*LLR_W-1:0] s_llr_a,
  input  logic [LANES*LLR_W-1:0] s_llr_b,
  input  logic [LANES-1:0]       s_ps,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*LLR_W-1:0] m_llr,
  output logic                   m_last,
  output logic [LANES-1:0]       m_sat,
  output logic [SATCNT_W-1:0]    sat_cnt
);

  localparam int unsigned POP_W = $clog2(LANES + 1);
  localparam int unsigned SUM_W = ((SATCNT_W > POP_W) ? SATCNT_W : POP_W) + 1;
  localparam logic [SATCNT_W-1:0] SAT_MAX = '1;

  logic              v1, v2;
  logic              ld1, ld2, acc, en2;
  logic              first, eff_mode, last_in;
  logic [BEAT_W-1:0] eff_len, cnt, len_q;
  logic              mode_q, mode1, last1;
  logic [POP_W-1:0]  pop;
  logic [SUM_W-1:0]  sat_sum;

  // Stage load enables, input acceptance and first/last-beat decode.
  always_comb begin
    ld2      = !v2 || m_ready;
    ld1      = !v1 || ld2;
    acc      = s_valid && ld1;
    en2      = ld2 && v1;
    first    = (cnt == '0);
    eff_mode = first ? s_mode : mode_q;
    eff_len  = first ? s_beats_m1 : len_q;
    last_in  = (cnt == eff_len);
  end

  assign s_ready = ld1;
  assign m_valid = v2;

  // Beat counter and per-node mode/length capture on the first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mode_q <= 1'b0;
      len_q  <= '0;
    end else if (acc) begin
      if (first) begin
        mode_q <= s_mode;
        len_q  <= s_beats_m1;
      end
      cnt <= last_in ? '0 : cnt + BEAT_W'(1);
    end
  end

  // Pipeline valids plus the per-beat mode and last sidebands.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      mode1  <= 1'b0;
      last1  <= 1'b0;
      m_last <= 1'b0;
    end else begin
      if (ld1) begin
        v1 <= acc;
      end
      if (acc) begin
        mode1 <= eff_mode;
        last1 <= last_in;
      end
      if (ld2) begin
        v2 <= v1;
      end
      if (en2) begin
        m_last <= last1;
      end
    end
  end

  // Per-lane datapath.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fg_pe_lane #(
      .LLR_W(LLR_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en1  (acc),
      .en2  (en2),
      .mode1(mode1),
      .a    (s_llr_a[i*LLR_W +: LLR_W]),
      .b    (s_llr_b[i*LLR_W +: LLR_W]),
      .ps   (s_ps[i]),
      .res  (m_llr[i*LLR_W +: LLR_W]),
      .sat  (m_sat[i])
    );
  end

  // Saturated lanes on the current output beat, and the clamped running total.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + POP_W'(m_sat[i]);
    end
    sat_sum = SUM_W'(sat_cnt) + SUM_W'(pop);
  end

  // Saturation event counter, sticky at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (v2 && m_ready) begin
      sat_cnt <= (sat_sum > SUM_W'(SAT_MAX)) ? SAT_MAX : SATCNT_W'(sat_sum);
    end
  end

endmodule
